text_cursor_ctrl: RTL and testbench
===================================

// Module: text_cursor_ctrl
// PURPOSE
//   Terminal-style write controller between the UART receiver and the text RAM write port.
//   Consumes received bytes, interprets control codes, tracks the cursor and issues one
//   registered RAM write per printable/erase action. Also runs a screen clear.
//   The VGA read side of the text RAM is untouched; the 7-seg debug shows cur_row/cur_col.
// PARAMETERS
//   COLS   32  characters per text row (power of two)
//   ROWS   4   text rows (power of two)
//   COL_W  5   log2(COLS), width of column index
//   ROW_W  2   log2(ROWS), width of row index
// PORTS
//   clk        in   1      system clock, 100 MHz
//   reset      in   1      asynchronous, active-low reset
//   rx_data    in   8      received byte from uart
//   rx_valid   in   1      one-cycle strobe, rx_data valid
//   rx_ready   out  1      1 = byte accepted this cycle; 0 while clearing
//   we         out  1      text RAM write enable, one cycle per write
//   w_row      out  ROW_W  text RAM write row
//   w_col      out  COL_W  text RAM write column
//   w_data     out  8      text RAM write data
//   cur_row    out  ROW_W  current cursor row
//   cur_col    out  COL_W  current cursor column
//   dropped    out  1      sticky: a byte arrived while rx_ready=0
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, cursor=(0,0), we=0, w_row=0, w_col=0,
//     w_data=0, rx_ready=1, dropped=0. Reset mid-clear aborts the clear immediately.
//   States: IDLE (rx_ready=1), CLEAR (rx_ready=0). Acceptance = rx_valid && rx_ready.
//   All outputs registered; accepted byte in cycle N -> we/w_* in cycle N+1, cursor
//   updated in cycle N+1. One byte per cycle sustained in IDLE.
//   Byte decode on acceptance:
//   - 0x20..0x7E printable: write byte at cursor, then advance cursor.
//   - 0x0A LF or 0x0D CR: no write; col=0, row=row+1 (mod ROWS).
//   - 0x08 BS: step cursor back one cell then write 0x20 there. From col 0 go to
//     (row-1, COLS-1); at (0,0) no write, cursor unchanged.
//   - 0x0C FF: enter CLEAR; no write in cycle N+1 from the FF itself.
//   - any other byte (incl. 0x7F, >=0x80): ignored, no write, cursor unchanged.
//   Advance: col+1; col=COLS-1 wraps to col 0 of row+1; row ROWS-1 wraps to row 0
//     (no scrolling; old text is overwritten).
//   CLEAR: sweep counter writes 0x20 to every cell, one per cycle, row-major from (0,0)
//     to (ROWS-1,COLS-1): exactly ROWS*COLS writes. After last write: cursor=(0,0),
//     state=IDLE, rx_ready=1 next cycle. rx_ready=0 from cycle after FF acceptance until
//     the cycle after the last sweep write.
//   rx_valid while rx_ready=0: byte discarded, dropped<=1 (cleared only by reset).
//   Arithmetic: cursor fields wrap naturally in COL_W/ROW_W bits; no saturation.
// STRUCTURE
//   Shared package text_pkg: ASCII constants (BS, LF, CR, FF, SPACE, PRINT_LO/HI),
//     COLS/ROWS/COL_W/ROW_W defaults, state encoding constants.
//   One natural sub-module: clear_sweeper (counter ROW_W+COL_W bits, start/done,
//     row/col outputs). Byte decode and cursor arithmetic stay in this module.
// TESTING
//   1. After reset, send 'A'(0x41) -> next cycle we=1, w_row=0, w_col=0, w_data=0x41;
//      cursor=(0,1); no other we pulses.
//   2. Send 32 x 0x41 then 'B' -> 'B' written at (1,0); cursor=(1,1).
//   3. Cursor (3,5), send LF -> no write, cursor=(0,0); send CR at (2,7) -> (3,0).
//   4. Cursor (1,0), send BS -> we with (0,31,0x20), cursor=(0,31); BS at (0,0) -> no we.
//   5. Send FF -> exactly 128 we pulses of 0x20 covering all cells, rx_ready low 128
//      cycles; byte sent mid-clear -> no write, dropped=1; cursor=(0,0) after.
//   6. Assert reset during clear sweep -> outputs at reset values at once; after release
//      'Z' is written at (0,0). Also send 0x07 -> no write, cursor unchanged.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants and types for the text cursor write controller.
package text_pkg;

    // Default screen geometry
    localparam int COLS  = 32;
    localparam int ROWS  = 4;
    localparam int COL_W = 5;
    localparam int ROW_W = 2;

    // ASCII codes interpreted by the controller
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] PRINT_LO    = 8'h20;
    localparam logic [7:0] PRINT_HI    = 8'h7E;

    // Controller states: IDLE accepts bytes, CLEAR sweeps the screen
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Row-major cell counter used to blank the whole screen, one cell per step.
// Cell 0 is written by the parent on the start edge, so start preloads 1.
module clear_sweeper #(
    parameter int ROW_W = 2,
    parameter int COL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             done
);
    localparam int CNT_W = ROW_W + COL_W;

    logic [CNT_W-1:0] cnt;

    // Counter advances per step; done flags once the last cell has been issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (start) begin
            cnt  <= CNT_W'(1);
            done <= 1'b0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (&cnt)
                done <= 1'b1;
        end
    end

    assign {row, col} = cnt;

endmodule

// File: rtl/text_cursor_ctrl.sv
// Terminal-style write controller: decodes UART bytes into text RAM writes,
// tracks the cursor and runs a full-screen clear on form feed.
module text_cursor_ctrl
    import text_pkg::*;
#(
    parameter int COLS  = 32,
    parameter int ROWS  = 4,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             we,
    output logic [ROW_W-1:0] w_row,
    output logic [COL_W-1:0] w_col,
    output logic [7:0]       w_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             dropped
);

    state_t           state, state_d;
    logic             rx_ready_d, we_d, dropped_d;
    logic [ROW_W-1:0] w_row_d, cur_row_d;
    logic [COL_W-1:0] w_col_d, cur_col_d;
    logic [7:0]       w_data_d;

    logic             sweep_start, sweep_step, sweep_done;
    logic [ROW_W-1:0] sweep_row;
    logic [COL_W-1:0] sweep_col;
    logic             accept;

    assign accept = rx_valid && rx_ready;

    clear_sweeper #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .step  (sweep_step),
        .row   (sweep_row),
        .col   (sweep_col),
        .done  (sweep_done)
    );

    // State and all outputs are registered; the comb block computes their next values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rx_ready <= 1'b1;
            we       <= 1'b0;
            w_row    <= '0;
            w_col    <= '0;
            w_data   <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            dropped  <= 1'b0;
        end else begin
            state    <= state_d;
            rx_ready <= rx_ready_d;
            we       <= we_d;
            w_row    <= w_row_d;
            w_col    <= w_col_d;
            w_data   <= w_data_d;
            cur_row  <= cur_row_d;
            cur_col  <= cur_col_d;
            dropped  <= dropped_d;
        end
    end

    // Byte decode, cursor arithmetic and clear sequencing
    always_comb begin
        state_d     = state;
        rx_ready_d  = rx_ready;
        we_d        = 1'b0;
        w_row_d     = w_row;
        w_col_d     = w_col;
        w_data_d    = w_data;
        cur_row_d   = cur_row;
        cur_col_d   = cur_col;
        dropped_d   = dropped | (rx_valid & ~rx_ready);
        sweep_start = 1'b0;
        sweep_step  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(rx_data)) begin
                        we_d     = 1'b1;
                        w_row_d  = cur_row;
                        w_col_d  = cur_col;
                        w_data_d = rx_data;
                        // Treating {row,col} as one index gives col wrap into next row for free
                        {cur_row_d, cur_col_d} = {cur_row, cur_col} + (ROW_W + COL_W)'(1);
                    end else if (rx_data == ASCII_LF || rx_data == ASCII_CR) begin
                        cur_row_d = cur_row + ROW_W'(1);
                        cur_col_d = '0;
                    end else if (rx_data == ASCII_BS) begin
                        // Home position has nothing behind it: no erase, no move
                        if (cur_row != '0 || cur_col != '0) begin
                            {cur_row_d, cur_col_d} = {cur_row, cur_col} - (ROW_W + COL_W)'(1);
                            we_d     = 1'b1;
                            w_row_d  = cur_row_d;
                            w_col_d  = cur_col_d;
                            w_data_d = ASCII_SPACE;
                        end
                    end else if (rx_data == ASCII_FF) begin
                        // First sweep write (cell 0) goes out on this edge
                        state_d     = ST_CLEAR;
                        rx_ready_d  = 1'b0;
                        we_d        = 1'b1;
                        w_row_d     = '0;
                        w_col_d     = '0;
                        w_data_d    = ASCII_SPACE;
                        sweep_start = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (sweep_done) begin
                    state_d    = ST_IDLE;
                    rx_ready_d = 1'b1;
                    cur_row_d  = '0;
                    cur_col_d  = '0;
                end else begin
                    we_d       = 1'b1;
                    w_row_d    = sweep_row;
                    w_col_d    = sweep_col;
                    w_data_d   = ASCII_SPACE;
                    sweep_step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Self-checking bench for text_cursor_ctrl: linear-index screen model plus directed cases.
module tb_text_cursor_ctrl;
    localparam int COLS  = 32;
    localparam int ROWS  = 4;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready, we, dropped;
    logic [1:0] w_row, cur_row;
    logic [4:0] w_col, cur_col;
    logic [7:0] w_data;

    text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .w_row    (w_row),
        .w_col    (w_col),
        .w_data   (w_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit run = 1'b0;

    // Model: cursor as linear cell index, pending clear writes as a queue
    int m_pos, m_wrow, m_wcol, m_wdata;
    bit m_rdy, m_drop, m_we, m_clearing;
    int clr_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    task automatic model_reset();
        m_pos = 0; m_rdy = 1; m_drop = 0; m_we = 0;
        m_wrow = 0; m_wcol = 0; m_wdata = 0; m_clearing = 0;
        clr_q.delete();
    endtask

    task automatic model_write(input int idx, input int data);
        m_we = 1; m_wrow = idx / COLS; m_wcol = idx % COLS; m_wdata = data;
    endtask

    // Expected outputs after the next clock edge given this cycle's inputs
    task automatic model_step(input bit v, input int d);
        m_we = 0;
        if (m_clearing) begin
            if (v) m_drop = 1;
            if (clr_q.size() > 0) model_write(clr_q.pop_front(), 32);
            else begin m_clearing = 0; m_rdy = 1; m_pos = 0; end
        end else if (v) begin
            if (d >= 32 && d <= 126) begin
                model_write(m_pos, d);
                m_pos = (m_pos + 1) % CELLS;
            end else if (d == 10 || d == 13) begin
                m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
            end else if (d == 8) begin
                if (m_pos != 0) begin m_pos--; model_write(m_pos, 32); end
            end else if (d == 12) begin
                for (int i = 0; i < CELLS; i++) clr_q.push_back(i);
                m_clearing = 1; m_rdy = 0;
                model_write(clr_q.pop_front(), 32);
            end
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (run) begin
            chk("we", we, m_we);
            if (m_we) begin
                chk("w_row", w_row, m_wrow);
                chk("w_col", w_col, m_wcol);
                chk("w_data", w_data, m_wdata);
            end
            chk("rx_ready", rx_ready, m_rdy);
            chk("dropped", dropped, m_drop);
            chk("cur_row", cur_row, m_pos / COLS);
            chk("cur_col", cur_col, m_pos % COLS);
        end
    end

    // Drive one cycle of input; returns at negedge+1 with outputs of that edge settled
    task automatic cycle(input bit v, input int d);
        rx_valid = v;
        rx_data  = 8'(d);
        model_step(v, d);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_we", we, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_dropped", dropped, 0);
        chk("rst_cur", {cur_row, cur_col}, 0);
        chk("rst_w", {w_row, w_col, w_data}, 0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic send_n(input int n, input int d);
        for (int i = 0; i < n; i++) cycle(1, d);
    endtask

    initial begin
        int we_cnt, low_cnt, covered, b, r;
        bit cov[CELLS];

        #1;
        do_reset();
        run = 1'b1;

        // 1: single printable from reset
        cycle(1, 8'h41);
        chk("t1_we", we, 1);
        chk("t1_w", {w_row, w_col, w_data}, {2'd0, 5'd0, 8'h41});
        chk("t1_cur", {cur_row, cur_col}, {2'd0, 5'd1});
        cycle(0, 0);
        chk("t1_no_extra_we", we, 0);

        // 2: line wrap after a full row
        do_reset();
        send_n(32, 8'h41);
        cycle(1, 8'h42);
        chk("t2_w", {w_row, w_col, w_data}, {2'd1, 5'd0, 8'h42});
        chk("t2_cur", {cur_row, cur_col}, {2'd1, 5'd1});

        // 3: LF from last row wraps to top, CR from row 2
        do_reset();
        send_n(3, 8'h0A);
        send_n(5, 8'h78);
        chk("t3_pre", {cur_row, cur_col}, {2'd3, 5'd5});
        cycle(1, 8'h0A);
        chk("t3_lf_we", we, 0);
        chk("t3_lf_cur", {cur_row, cur_col}, 0);
        send_n(2, 8'h0D);
        send_n(7, 8'h78);
        cycle(1, 8'h0D);
        chk("t3_cr_cur", {cur_row, cur_col}, {2'd3, 5'd0});

        // 4: backspace across a row boundary, and at home
        do_reset();
        cycle(1, 8'h0A);
        cycle(1, 8'h08);
        chk("t4_bs_w", {we, w_row, w_col, w_data}, {1'b1, 2'd0, 5'd31, 8'h20});
        chk("t4_bs_cur", {cur_row, cur_col}, {2'd0, 5'd31});
        do_reset();
        cycle(1, 8'h08);
        chk("t4_bs_home_we", we, 0);
        chk("t4_bs_home_cur", {cur_row, cur_col}, 0);

        // 5: full clear with a byte dropped mid-sweep
        do_reset();
        send_n(9, 8'h61);
        for (int i = 0; i < CELLS; i++) cov[i] = 0;
        cycle(1, 8'h0C);
        we_cnt = 0; low_cnt = 0;
        for (int i = 0; i < 200 && !rx_ready; i++) begin
            low_cnt++;
            if (we) begin
                we_cnt++;
                if (w_data == 8'h20) cov[w_row * COLS + w_col] = 1;
            end
            cycle(i == 50, 8'h51);
        end
        covered = 0;
        for (int i = 0; i < CELLS; i++) covered += cov[i];
        chk("t5_done", rx_ready, 1);
        chk("t5_we_pulses", we_cnt, 128);
        chk("t5_ready_low", low_cnt, 128);
        chk("t5_cells_covered", covered, 128);
        chk("t5_dropped", dropped, 1);
        chk("t5_cur", {cur_row, cur_col}, 0);

        // 6: reset in the middle of a sweep, then normal writes
        do_reset();
        send_n(4, 8'h61);
        cycle(1, 8'h0C);
        send_n(40, 0);
        chk("t6_mid_clear", rx_ready, 0);
        do_reset();
        cycle(1, 8'h5A);
        chk("t6_z", {we, w_row, w_col, w_data}, {1'b1, 2'd0, 5'd0, 8'h5A});
        cycle(1, 8'h07);
        chk("t6_bel_we", we, 0);
        chk("t6_bel_cur", {cur_row, cur_col}, {2'd0, 5'd1});

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = $urandom_range(32, 126);
            else if (r < 62) b = ($urandom_range(0, 1) != 0) ? 10 : 13;
            else if (r < 72) b = 8;
            else if (r < 73) b = 12;
            else             b = $urandom_range(0, 255);
            cycle($urandom_range(0, 9) < 7, b);
        end
        cycle(0, 0);

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
